// File: rtl/bsc_pkg.sv
// Shared definitions for the bit-serial CPU execution sequencer.
// Holds opcode and ALU-select encodings, instr field positions, the sequencer
// state enum and the opcode decode table.
package bsc_pkg;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpSub  = 4'd2;
  localparam logic [3:0] OpAnd  = 4'd3;
  localparam logic [3:0] OpOr   = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpLdi  = 4'd6;
  localparam logic [3:0] OpMov  = 4'd7;
  localparam logic [3:0] OpAddi = 4'd8;
  localparam logic [3:0] OpHalt = 4'd15;

  localparam logic [2:0] AluPass = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluSub  = 3'd2;
  localparam logic [2:0] AluAnd  = 3'd3;
  localparam logic [2:0] AluOr   = 3'd4;
  localparam logic [2:0] AluXor  = 3'd5;
  localparam logic [2:0] AluImm  = 3'd6;

  localparam int unsigned InstrRdLsb  = 0;
  localparam int unsigned InstrRs1Lsb = 2;
  localparam int unsigned InstrRs2Lsb = 4;
  localparam int unsigned InstrImmLsb = 4;

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StDone, StHalt} state_e;

  typedef enum logic [1:0] {KindNop, KindExec, KindHalt} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [2:0] alu_op;
    logic       src_imm;
    logic       upd_zero;
    logic       upd_carry;
    logic       sub;
  } dec_t;

  // Illegal opcodes (9..14) fall through to the NOP defaults.
  function automatic dec_t decode(logic [3:0] op);
    dec_t d;
    d.kind      = KindNop;
    d.alu_op    = AluPass;
    d.src_imm   = 1'b0;
    d.upd_zero  = 1'b0;
    d.upd_carry = 1'b0;
    d.sub       = 1'b0;
    case (op)
      OpAdd: begin
        d.kind = KindExec; d.alu_op = AluAdd; d.upd_zero = 1'b1; d.upd_carry = 1'b1;
      end
      OpSub: begin
        d.kind = KindExec; d.alu_op = AluSub; d.upd_zero = 1'b1; d.upd_carry = 1'b1;
        d.sub = 1'b1;
      end
      OpAnd: begin d.kind = KindExec; d.alu_op = AluAnd; d.upd_zero = 1'b1; end
      OpOr:  begin d.kind = KindExec; d.alu_op = AluOr;  d.upd_zero = 1'b1; end
      OpXor: begin d.kind = KindExec; d.alu_op = AluXor; d.upd_zero = 1'b1; end
      OpLdi: begin d.kind = KindExec; d.alu_op = AluImm; d.src_imm = 1'b1; end
      OpMov: begin d.kind = KindExec; d.alu_op = AluPass; end
      OpAddi: begin
        d.kind = KindExec; d.alu_op = AluAdd; d.src_imm = 1'b1;
        d.upd_zero = 1'b1; d.upd_carry = 1'b1;
      end
      OpHalt: d.kind = KindHalt;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bsc_exec_sequencer_if.sv
// Instruction-in / datapath-control bundle of the execution sequencer.
// master: instruction loader + datapath side (drives inst_valid, opcode, instr,
//         alu_bit, carry_out). slave: the sequencer (drives all control/flags).
interface bsc_exec_sequencer_if #(
  parameter int unsigned W = 8
);
  localparam int unsigned IDX_W = $clog2(W);

  logic             inst_valid;
  logic [3:0]       opcode;
  logic [11:0]      instr;
  logic             alu_bit;
  logic             carry_out;

  logic             busy;
  logic             shift_en;
  logic [IDX_W-1:0] bit_idx;
  logic [2:0]       alu_op;
  logic             carry_in;
  logic [1:0]       rd_sel;
  logic [1:0]       rs1_sel;
  logic [1:0]       rs2_sel;
  logic             src_imm;
  logic             imm_bit;
  logic             wb_en;
  logic             done;
  logic             zero_flag;
  logic             carry_flag;
  logic             overrun;
  logic             halted;

  modport master (
    output inst_valid, opcode, instr, alu_bit, carry_out,
    input  busy, shift_en, bit_idx, alu_op, carry_in, rd_sel, rs1_sel, rs2_sel,
           src_imm, imm_bit, wb_en, done, zero_flag, carry_flag, overrun, halted
  );

  modport slave (
    input  inst_valid, opcode, instr, alu_bit, carry_out,
    output busy, shift_en, bit_idx, alu_op, carry_in, rd_sel, rs1_sel, rs2_sel,
           src_imm, imm_bit, wb_en, done, zero_flag, carry_flag, overrun, halted
  );

endinterface

// File: rtl/bsc_exec_sequencer.sv
// Control FSM of the bit-serial CPU core. Latches one instruction, decodes it,
// then drives W LSB-first shift cycles with ALU select, carry and writeback
// strobes. Owns the carry/zero flags and the sticky overrun indication.
// Ports: clk, rst_n (async active-low), bus_io (slave side of the sequencer
// interface: instruction handshake in, datapath control and flags out).
module bsc_exec_sequencer
  import bsc_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  bsc_exec_sequencer_if.slave  bus_io
);
  localparam int unsigned IDX_W = $clog2(W);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [1:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [7:0]       imm_q, imm_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic             zflag_q, zflag_d;
  logic             cflag_q, cflag_d;
  logic             overrun_q, overrun_d;
  logic             shift_en, wb_en, done, imm_bit;
  dec_t             dec;

  assign dec = decode(op_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    bit_idx_d = bit_idx_q;
    carry_d   = carry_q;
    zacc_d    = zacc_q;
    zflag_d   = zflag_q;
    cflag_d   = cflag_q;
    overrun_d = overrun_q | (bus_io.inst_valid & (state_q != StIdle));
    shift_en  = 1'b0;
    wb_en     = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.inst_valid) begin
          op_d    = bus_io.opcode;
          rd_d    = bus_io.instr[InstrRdLsb +: 2];
          rs1_d   = bus_io.instr[InstrRs1Lsb +: 2];
          rs2_d   = bus_io.instr[InstrRs2Lsb +: 2];
          imm_d   = bus_io.instr[InstrImmLsb +: 8];
          state_d = StDecode;
        end
      end
      StDecode: begin
        // SUB seeds the +1 of the two's complement at bit 0.
        carry_d   = dec.sub;
        zacc_d    = 1'b1;
        bit_idx_d = '0;
        case (dec.kind)
          KindExec: state_d = StExec;
          KindHalt: state_d = StHalt;
          default:  state_d = StDone;
        endcase
      end
      StExec: begin
        shift_en = 1'b1;
        wb_en    = 1'b1;  // NOP never reaches EXEC
        carry_d  = bus_io.carry_out;
        zacc_d   = zacc_q & ~bus_io.alu_bit;
        if (bit_idx_q == IDX_W'(W - 1)) begin
          state_d = StDone;
        end else begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      StDone: begin
        done = 1'b1;
        if (dec.upd_zero)  zflag_d = zacc_q;
        if (dec.upd_carry) cflag_d = carry_q;
        state_d = StIdle;
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  // imm8 bit select; positions at or above 8 (wide W) read as 0.
  always_comb begin
    imm_bit = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < W && bit_idx_q == IDX_W'(i)) imm_bit = imm_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      bit_idx_q <= '0;
      carry_q   <= 1'b0;
      zacc_q    <= 1'b0;
      zflag_q   <= 1'b0;
      cflag_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      bit_idx_q <= bit_idx_d;
      carry_q   <= carry_d;
      zacc_q    <= zacc_d;
      zflag_q   <= zflag_d;
      cflag_q   <= cflag_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus_io.busy       = (state_q != StIdle);
  assign bus_io.halted     = (state_q == StHalt);
  assign bus_io.shift_en   = shift_en;
  assign bus_io.wb_en      = wb_en;
  assign bus_io.done       = done;
  assign bus_io.bit_idx    = bit_idx_q;
  assign bus_io.alu_op     = dec.alu_op;
  assign bus_io.src_imm    = dec.src_imm;
  assign bus_io.imm_bit    = imm_bit;
  assign bus_io.carry_in   = carry_q;
  assign bus_io.rd_sel     = rd_q;
  assign bus_io.rs1_sel    = rs1_q;
  assign bus_io.rs2_sel    = rs2_q;
  assign bus_io.zero_flag  = zflag_q;
  assign bus_io.carry_flag = cflag_q;
  assign bus_io.overrun    = overrun_q;

endmodule

// File: tb/tb_bsc_exec_sequencer.sv
// Self-checking bench for bsc_exec_sequencer: table of instructions run through
// a serial datapath model, plus hand sequences for HALT, overrun and async reset.
module tb_bsc_exec_sequencer;
  import bsc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsc_exec_sequencer_if #(.W(8)) bus ();

  bsc_exec_sequencer #(.W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int total = 0;
  int bad = 0;

  // Serial datapath model: operand snapshots ra/rb, full adder, ALU mux.
  logic [7:0] ra, rb;
  logic a_b, b_b, sum_b, cout_b, res_b;
  always_comb begin
    a_b    = ra[bus.bit_idx];
    b_b    = bus.src_imm ? bus.imm_bit : rb[bus.bit_idx];
    if (bus.alu_op == AluSub) b_b = ~b_b;
    sum_b  = a_b ^ b_b ^ bus.carry_in;
    cout_b = (a_b & b_b) | (bus.carry_in & (a_b ^ b_b));
    case (bus.alu_op)
      AluAdd, AluSub: res_b = sum_b;
      AluAnd:         res_b = a_b & b_b;
      AluOr:          res_b = a_b | b_b;
      AluXor:         res_b = a_b ^ b_b;
      AluImm:         res_b = b_b;
      default:        res_b = a_b;
    endcase
  end
  assign bus.alu_bit   = res_b;
  assign bus.carry_out = cout_b;

  typedef struct {
    logic [3:0]  op;
    logic [11:0] instr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  rd;
    logic        z;
    logic        c;
    int          shifts;
    int          done_lat;
    logic [2:0]  alu;
    logic        simm;
    logic        cin0;
    logic        chk_rd;
    logic        chk_imm;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_inst(input vec_t v, input bit glitch);
    logic [7:0] res, immseq;
    logic       cin0;
    int nshift, nwb, done_n;
    res = '0; immseq = '0; cin0 = 1'b0; nshift = 0; nwb = 0; done_n = 0;
    ra = v.a; rb = v.b;
    @(negedge clk);
    bus.inst_valid = 1'b1; bus.opcode = v.op; bus.instr = v.instr;
    for (int n = 1; n <= 40 && done_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) bus.inst_valid = 1'b0;
      if (glitch && n == 5) begin
        chk("glitch_bit_idx", 32'(bus.bit_idx), 3);
        bus.inst_valid = 1'b1; bus.opcode = OpSub;
      end
      if (glitch && n == 6) begin
        bus.inst_valid = 1'b0;
        chk("overrun_rise", 32'(bus.overrun), 1);
      end
      if (bus.shift_en) begin
        nshift++;
        if (bus.bit_idx == 3'd0) cin0 = bus.carry_in;
        immseq[bus.bit_idx] = bus.imm_bit;
      end
      if (bus.wb_en) begin
        nwb++;
        res[bus.bit_idx] = bus.alu_bit;
      end
      if (bus.done) begin
        done_n = n;
        chk("alu_op", 32'(bus.alu_op), 32'(v.alu));
        chk("src_imm", 32'(bus.src_imm), 32'(v.simm));
        chk("rd_sel", 32'(bus.rd_sel), 32'(v.instr[1:0]));
        chk("rs1_sel", 32'(bus.rs1_sel), 32'(v.instr[3:2]));
        if (glitch) bus.inst_valid = 1'b1;
      end
    end
    @(negedge clk);
    bus.inst_valid = 1'b0;
    chk("done_latency", 32'(done_n), 32'(v.done_lat));
    chk("shift_count", 32'(nshift), 32'(v.shifts));
    chk("wb_count", 32'(nwb), 32'(v.shifts));
    chk("busy_after_done", 32'(bus.busy), 0);
    chk("zero_flag", 32'(bus.zero_flag), 32'(v.z));
    chk("carry_flag", 32'(bus.carry_flag), 32'(v.c));
    chk("overrun", 32'(bus.overrun), 32'(glitch));
    if (v.chk_rd) chk("rd_value", 32'(res), 32'(v.rd));
    if (v.shifts > 0) chk("carry_in_bit0", 32'(cin0), 32'(v.cin0));
    if (v.chk_imm) chk("imm_seq", 32'(immseq), 32'(v.instr[11:4]));
  endtask

  function automatic logic [22:0] all_outs();
    return {bus.busy, bus.shift_en, bus.bit_idx, bus.alu_op, bus.carry_in, bus.rd_sel,
            bus.rs1_sel, bus.rs2_sel, bus.src_imm, bus.imm_bit, bus.wb_en, bus.done,
            bus.zero_flag, bus.carry_flag, bus.overrun, bus.halted};
  endfunction

  initial begin
    //          op      instr    a      b      rd     z  c  sh dl alu  si ci rd im
    vecs[0]  = '{OpAdd,  12'h039, 8'hC8, 8'h38, 8'h00, 1, 1, 8, 10, 3'd1, 0, 0, 1, 0};
    vecs[1]  = '{OpSub,  12'h039, 8'h05, 8'h07, 8'hFE, 0, 0, 8, 10, 3'd2, 0, 1, 1, 0};
    vecs[2]  = '{OpLdi,  12'hA52, 8'h00, 8'h00, 8'hA5, 0, 0, 8, 10, 3'd6, 1, 0, 1, 1};
    vecs[3]  = '{OpAnd,  12'h039, 8'hF0, 8'h3C, 8'h30, 0, 0, 8, 10, 3'd3, 0, 0, 1, 0};
    vecs[4]  = '{OpXor,  12'h039, 8'h5A, 8'h5A, 8'h00, 1, 0, 8, 10, 3'd5, 0, 0, 1, 0};
    vecs[5]  = '{OpOr,   12'h039, 8'h81, 8'h02, 8'h83, 0, 0, 8, 10, 3'd4, 0, 0, 1, 0};
    vecs[6]  = '{OpAddi, 12'h013, 8'hFF, 8'h00, 8'h00, 1, 1, 8, 10, 3'd1, 1, 0, 1, 0};
    vecs[7]  = '{OpMov,  12'h039, 8'h3C, 8'h00, 8'h3C, 1, 1, 8, 10, 3'd0, 0, 0, 1, 0};
    vecs[8]  = '{OpNop,  12'h039, 8'h00, 8'h00, 8'h00, 1, 1, 0, 2,  3'd0, 0, 0, 0, 0};
    vecs[9]  = '{4'd12,  12'h039, 8'h00, 8'h00, 8'h00, 1, 1, 0, 2,  3'd0, 0, 0, 0, 0};
    vecs[10] = '{OpAdd,  12'h039, 8'h01, 8'h01, 8'h02, 0, 0, 8, 10, 3'd1, 0, 0, 1, 0};

    bus.inst_valid = 1'b0; bus.opcode = '0; bus.instr = '0;
    ra = '0; rb = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(all_outs()), 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_inst(vecs[i], 1'b0);

    // HALT is terminal; a later inst_valid only raises overrun.
    @(negedge clk);
    bus.inst_valid = 1'b1; bus.opcode = OpHalt; bus.instr = '0;
    @(negedge clk);
    bus.inst_valid = 1'b0;
    @(negedge clk);
    chk("halted", 32'(bus.halted), 1);
    chk("halt_busy", 32'(bus.busy), 1);
    chk("halt_overrun_clear", 32'(bus.overrun), 0);
    bus.inst_valid = 1'b1; bus.opcode = OpAdd;
    @(negedge clk);
    bus.inst_valid = 1'b0;
    chk("halt_overrun_set", 32'(bus.overrun), 1);
    repeat (5) @(negedge clk);
    chk("halted_stays", 32'(bus.halted), 1);
    chk("halt_no_shift", 32'(bus.shift_en), 0);
    #2 rst_n = 1'b0;
    #1 chk("halt_reset_outputs", 32'(all_outs()), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Async reset mid-EXEC at bit 5.
    ra = 8'hC8; rb = 8'h38;
    @(negedge clk);
    bus.inst_valid = 1'b1; bus.opcode = OpAdd; bus.instr = 12'h039;
    @(negedge clk);
    bus.inst_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_bit_idx", 32'(bus.bit_idx), 5);
    chk("pre_reset_shift", 32'(bus.shift_en), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'(all_outs()), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(bus.busy), 0);
    run_inst(vecs[0], 1'b0);

    // Ignored inst_valid at EXEC bit 3 and in DONE.
    run_inst(vecs[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
